// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - boot loader and run sequencer for the single-cycle RV64 core
// Optional load checksum accumulator is built when BOOT_CTRL_CHECKSUM_EN is defined.
module cpu_boot_ctrl #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int CYC_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(IMEM_WORDS):0]   imem_len,
    input  logic [$clog2(DMEM_WORDS):0]   dmem_len,
    input  logic [CYC_W-1:0]              run_cycles,
    input  logic                          halt_req,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [63:0]                   s_data,
    output logic [63:0]                   imem_addr_ext,
    output logic                          imem_wen_ext,
    output logic [31:0]                   imem_wdata_ext,
    output logic [63:0]                   dmem_addr_ext,
    output logic                          dmem_wen_ext,
    output logic [63:0]                   dmem_wdata_ext,
    output logic                          cpu_arst_n,
    output logic                          cpu_enable,
    output logic                          busy,
    output logic                          done,
    output logic [CYC_W-1:0]              cycles_run,
    output logic [63:0]                   checksum
);
    localparam int IW = $clog2(IMEM_WORDS) + 1;
    localparam int DW = $clog2(DMEM_WORDS) + 1;
    localparam int CW = (IW > DW) ? IW : DW;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_I = 3'd1,
        LOAD_D = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ilen_q, ilen_d, ilen_clamp;
    logic [DW-1:0]     dlen_q, dlen_d, dlen_clamp;
    logic [CYC_W-1:0]  budget_q, budget_d, cyc_q, cyc_d, cyc_inc;
    logic [CW-1:0]     beat_q, beat_d;
    logic [63:0]       imem_addr_q, imem_addr_d, dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              imem_wen_q, imem_wen_d, dmem_wen_q, dmem_wen_d;
    logic              arst_n_q, arst_n_d, enable_q, enable_d;
    logic              beat, last_i, last_d, budget_hit;

    assign s_ready = (state_q == LOAD_I) || (state_q == LOAD_D);
    assign beat    = s_valid && s_ready;

    always_comb begin
        ilen_clamp = (imem_len > IW'(IMEM_WORDS)) ? IW'(IMEM_WORDS) : imem_len;
        dlen_clamp = (dmem_len > DW'(DMEM_WORDS)) ? DW'(DMEM_WORDS) : dmem_len;
        last_i     = (beat_q + 1'b1) == CW'(ilen_q);
        last_d     = (beat_q + 1'b1) == CW'(dlen_q);
        cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
        // Budget expires on the edge that closes the N-th enabled cycle.
        budget_hit = enable_q && (budget_q != '0) && (cyc_inc == budget_q);
    end

    always_comb begin
        state_d      = state_q;
        ilen_d       = ilen_q;
        dlen_d       = dlen_q;
        budget_d     = budget_q;
        cyc_d        = cyc_q;
        beat_d       = beat_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_wen_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_wen_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ilen_d   = ilen_clamp;
                    dlen_d   = dlen_clamp;
                    budget_d = run_cycles;
                    cyc_d    = '0;
                    beat_d   = '0;
                    if (ilen_clamp != '0)      state_d = LOAD_I;
                    else if (dlen_clamp != '0) state_d = LOAD_D;
                    else                       state_d = RUN;
                end
            end
            LOAD_I: begin
                if (beat) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = 64'(beat_q) << 2;
                    imem_wdata_d = s_data[31:0];
                    beat_d       = beat_q + 1'b1;
                    if (last_i) begin
                        beat_d  = '0;
                        state_d = (dlen_q != '0) ? LOAD_D : RUN;
                    end
                end
            end
            LOAD_D: begin
                if (beat) begin
                    dmem_wen_d   = 1'b1;
                    dmem_addr_d  = 64'(beat_q) << 3;
                    dmem_wdata_d = s_data;
                    beat_d       = beat_q + 1'b1;
                    if (last_d) begin
                        beat_d  = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (enable_q) cyc_d = cyc_inc;
                if (halt_req || budget_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Core reset releases one cycle into RUN; enable follows a cycle later.
        arst_n_d = ((state_q == RUN)  && ((state_d == RUN) || (state_d == DONE))) ||
                   ((state_q == DONE) && (state_d == DONE));
        enable_d = (state_q == RUN) && (state_d == RUN) && arst_n_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ilen_q       <= '0;
            dlen_q       <= '0;
            budget_q     <= '0;
            cyc_q        <= '0;
            beat_q       <= '0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            imem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wen_q   <= 1'b0;
            arst_n_q     <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ilen_q       <= ilen_d;
            dlen_q       <= dlen_d;
            budget_q     <= budget_d;
            cyc_q        <= cyc_d;
            beat_q       <= beat_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_wen_q   <= imem_wen_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wen_q   <= dmem_wen_d;
            arst_n_q     <= arst_n_d;
            enable_q     <= enable_d;
        end
    end

`ifdef BOOT_CTRL_CHECKSUM_EN
    logic [63:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (((state_q == IDLE) || (state_q == DONE)) && start) begin
            checksum_d = '0;
        end else if (beat) begin
            checksum_d = {checksum_q[62:0], checksum_q[63]} ^
                         ((state_q == LOAD_I) ? {32'b0, s_data[31:0]} : s_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = 64'd0;
`endif

    assign imem_addr_ext  = imem_addr_q;
    assign imem_wdata_ext = imem_wdata_q;
    assign imem_wen_ext   = imem_wen_q;
    assign dmem_addr_ext  = dmem_addr_q;
    assign dmem_wdata_ext = dmem_wdata_q;
    assign dmem_wen_ext   = dmem_wen_q;
    assign cpu_arst_n     = arst_n_q;
    assign cpu_enable     = enable_q;
    assign busy           = (state_q == LOAD_I) || (state_q == LOAD_D) || (state_q == RUN);
    assign done           = (state_q == DONE);
    assign cycles_run     = cyc_q;

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
Boot and run sequencer for the single-cycle 64-bit RISC-V core.
- Accepts a valid/ready word stream and writes it through the core's external ports: first into instruction memory (32-bit words), then into data memory (64-bit words).
- Holds the core in reset while loading, then releases it and drives `enable` for a programmed cycle budget or until a halt request.
- Sits between the testbench or host link and the core's `addr_ext`/`wen_ext` and `addr_ext_2`/`wen_ext_2` ports.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in 32-bit words.
- DMEM_WORDS, 1024, data memory depth in 64-bit words.
- CYC_W, 32, width of the run-cycle budget and counter.

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  launch pulse; honoured only in IDLE or DONE.
- imem_len  in  $clog2(IMEM_WORDS)+1  instruction words to load; clamped to IMEM_WORDS.
- dmem_len  in  $clog2(DMEM_WORDS)+1  data words to load; clamped to DMEM_WORDS.
- run_cycles  in  CYC_W  enable-cycle budget; 0 means unlimited.
- halt_req  in  1  stop run; effective only in RUN.
- s_valid  in  1  load stream word valid.
- s_ready  out  1  load stream ready.
- s_data  in  64  load word; bits [31:0] are used in the instruction phase.
- imem_addr_ext  out  64  instruction memory byte address.
- imem_wen_ext  out  1  instruction memory write strobe.
- imem_wdata_ext  out  32  instruction word.
- dmem_addr_ext  out  64  data memory byte address.
- dmem_wen_ext  out  1  data memory write strobe.
- dmem_wdata_ext  out  64  data word.
- cpu_arst_n  out  1  core reset, low = held in reset.
- cpu_enable  out  1  core enable.
- busy  out  1  high in LOAD_I, LOAD_D and RUN.
- done  out  1  high in DONE.
- cycles_run  out  CYC_W  enable cycles elapsed in the last or current run.
- checksum  out  64  load checksum (see Optional Feature).

Behaviour:

States: IDLE=0, LOAD_I=1, LOAD_D=2, RUN=3, DONE=4.

Reset:
- Takes effect on the clock edge.
- State goes to IDLE; all write strobes, s_ready, cpu_enable, busy, done go to 0.
- cpu_arst_n=0; addresses, wdata, cycles_run, checksum go to 0.
- Reset in any state, including mid-load or mid-run, aborts with no further writes.

start in IDLE or DONE:
- Latches clamped imem_len, dmem_len, and run_cycles.
- Clears done, cycles_run, checksum, and both word counters.
- Next state: LOAD_I if imem_len≠0, else LOAD_D if dmem_len≠0, else RUN.
- start in any other state is ignored.

s_ready:
- Combinational, equal to (state==LOAD_I || state==LOAD_D).
- A beat transfers when s_valid && s_ready.
- Only transferred beats count; gaps in s_valid are allowed.

LOAD_I:
- Beat k (k=0..imem_len-1) is registered for the next cycle: imem_addr_ext=4*k, imem_wdata_ext=s_data[31:0], imem_wen_ext=1 for exactly that one cycle.
- After beat imem_len-1, next state is LOAD_D if dmem_len≠0, else RUN.

LOAD_D:
- Same scheme: dmem_addr_ext=8*k, dmem_wdata_ext=s_data, dmem_wen_ext=1 for one cycle.
- After beat dmem_len-1, next state is RUN.

Write-strobe timing:
- The last write strobe overlaps the first cycle of the next state.
- cpu_arst_n stays 0 during that cycle because it is registered from the state.

cpu_arst_n:
- 0 in IDLE, LOAD_I, LOAD_D.
- Goes to 1 one cycle after entering RUN, so the core reset release precedes enable.
- Stays 1 in DONE.

RUN:
- First cycle: cpu_arst_n rises; cpu_enable stays 0.
- Following cycles: cpu_enable=1 and cycles_run increments each cycle.
- With run_cycles=N>0, cpu_enable is high for exactly N cycles, then the state moves to DONE and cpu_enable=0.
- With run_cycles=0, the run continues until halt_req.
- halt_req sampled high in RUN: the next edge goes to DONE, and cpu_enable is low from that edge.
- Budget expiry and halt_req in the same cycle: go to DONE; cycles_run equals the value at that edge.

DONE:
- done=1; held until start or rst.
- External host may read memories via the core's ext ports.

cycles_run saturates at all-ones.

Optional Feature:
Macro: BOOT_CTRL_CHECKSUM_EN
- Defined: checksum is updated each transferred beat as checksum = {checksum[62:0],checksum[63]} ^ word, where word = {32'b0,s_data[31:0]} in LOAD_I and s_data in LOAD_D. It is cleared on start and rst and stable in RUN/DONE.
- Undefined: checksum is tied to 64'd0 and no accumulator register is built.

Test Plan:
1. Assert rst for 2 cycles mid-LOAD_D (after 1 data beat) → next cycle state=IDLE, dmem_wen_ext=0, s_ready=0, cpu_arst_n=0, done=0; no further writes.
2. start with imem_len=3, dmem_len=2, run_cycles=4; stream 0x00500093, 0x00A00113, 0x002081B3, 0x1111, 0x2222 with s_valid continuous → imem writes (0,0x00500093), (4,0x00A00113), (8,0x002081B3); dmem writes (0,0x1111), (8,0x2222); one strobe per beat.
3. Continue case 2 → cpu_arst_n rises first RUN cycle; cpu_enable high exactly 4 cycles; then done=1, cycles_run=4, busy=0.
4. imem_len=2 with s_valid toggling 1,0,0,1 → exactly 2 imem writes at addresses 0 and 4; s_ready held 1 through the gaps.
5. imem_len=0, dmem_len=0, run_cycles=0; halt_req asserted at the 7th enable cycle → IDLE→RUN directly, cpu_enable drops next edge, cycles_run=7, done=1; start in DONE relaunches with done cleared.
6. With BOOT_CTRL_CHECKSUM_EN, load imem 0x1 then dmem 0x2 → checksum=0x0000000000000000 after imem beat ^ 0x1 = 0x1, then rotate-xor gives 0x2^0x2=0x0; without the macro → checksum=0.
